// File: rtl/plab4_net_router_output_ctrl_rr_if.sv
// Handshake bundle between the per-input request logic, the output-port
// arbiter and the downstream channel of one router output port.
interface plab4_net_router_output_ctrl_rr_if;
    logic [2:0] reqs;
    logic [2:0] grants;
    logic       out_val;
    logic       out_rdy;
    logic [1:0] sel;

    modport master (
        input  reqs,
        input  out_rdy,
        output grants,
        output out_val,
        output sel
    );

    modport slave (
        output reqs,
        output out_rdy,
        input  grants,
        input  out_val,
        input  sel
    );
endinterface

// File: rtl/plab4_net_router_output_ctrl_rr.sv
// Round-robin output-port arbiter for a 3-input router. Once a winner is
// stalled by the downstream channel it stays locked until it transfers or withdraws.
module plab4_net_router_output_ctrl_rr #(
    parameter int p_router_id = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    plab4_net_router_output_ctrl_rr_if.master    io
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [2:0] ptr;
    logic [2:0] ptr_next;
    logic [2:0] lock;
    logic [2:0] lock_next;
    logic [2:0] winner;
    logic       transfer;

    // First set request scanning upward from the one-hot priority pointer.
    function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [2:0] p);
        logic [2:0] pick;
        pick = 3'b000;
        case (p)
            3'b010: begin
                if      (r[1]) pick = 3'b010;
                else if (r[2]) pick = 3'b100;
                else if (r[0]) pick = 3'b001;
            end
            3'b100: begin
                if      (r[2]) pick = 3'b100;
                else if (r[0]) pick = 3'b001;
                else if (r[1]) pick = 3'b010;
            end
            default: begin
                if      (r[0]) pick = 3'b001;
                else if (r[1]) pick = 3'b010;
                else if (r[2]) pick = 3'b100;
            end
        endcase
        return pick;
    endfunction

    function automatic logic [1:0] onehot_index(input logic [2:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        if      (oh[1]) idx = 2'd1;
        else if (oh[2]) idx = 2'd2;
        return idx;
    endfunction

    always_comb begin
        winner     = 3'b000;
        state_next = state;
        ptr_next   = ptr;
        lock_next  = lock;

        if (state == LOCKED) begin
            winner = io.reqs & lock;
        end else begin
            winner = rr_pick(io.reqs, ptr);
        end

        transfer = (|winner) && io.out_rdy;

        // Priority moves to the input just after the one that transferred.
        if (transfer) begin
            ptr_next   = {winner[1:0], winner[2]};
            state_next = IDLE;
        end else if (state == IDLE && (|winner)) begin
            state_next = LOCKED;
            lock_next  = winner;
        end else if (state == LOCKED && !(|winner)) begin
            state_next = IDLE;
        end
    end

    assign io.out_val = (|winner) && !reset;
    assign io.grants  = winner & {3{io.out_rdy}} & {3{!reset}};
    assign io.sel     = onehot_index(winner);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= 3'b001;
            lock  <= 3'b000;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            lock  <= lock_next;
        end
    end

endmodule

// File: doc/plab4_net_router_output_ctrl_rr.md
PLAB4_NET_ROUTER_OUTPUT_CTRL_RR -- requirements
Module: plab4_net_router_output_ctrl_rr

Interface
REQ-001 The block SHALL have parameter p_router_id, default 0, meaning router index, informational only and not affecting function.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port reqs, input, 3 bits: per-input request, bit i means input i wants this output port.
REQ-005 The block SHALL have port grants, output, 3 bits: one-hot-or-zero grant; input i transfers this cycle iff grants[i].
REQ-006 The block SHALL have port out_val, output, 1 bit: valid toward the downstream channel.
REQ-007 The block SHALL have port out_rdy, input, 1 bit: ready from the downstream channel.
REQ-008 The block SHALL have port sel, output, 2 bits: mux select for the output datapath, encoded as 0, 1 or 2.

Function
REQ-009 The block SHALL hold a one-hot priority register ptr[2:0], where the set bit is the highest-priority input.
REQ-010 The block SHALL implement FSM states IDLE and LOCKED, plus a one-hot register lock[2:0].
REQ-011 In IDLE, winner SHALL be the first set bit of reqs, scanning from the ptr position upward with modulo-3 wrap (e.g. ptr=010 gives order 1,2,0); winner is 000 if reqs=000.
REQ-012 In LOCKED, winner SHALL equal reqs & lock, regardless of any other reqs bits.
REQ-013 The outputs SHALL be combinational: out_val = |winner; sel = index of winner (0 when winner=000); grants = winner & {3{out_rdy}}.
REQ-014 A transfer SHALL occur in a cycle with out_val=1 and out_rdy=1; on the next edge ptr becomes one-hot of (winner index + 1) mod 3 and the state becomes IDLE.
REQ-015 In IDLE, if out_val=1 and out_rdy=0, the next state SHALL be LOCKED with lock=winner; ptr is unchanged.
REQ-016 In LOCKED with reqs & lock = 000 (requester withdrew), the block SHALL drive out_val=0 and grants=000, move to IDLE on the next edge, and leave ptr unchanged.
REQ-017 In LOCKED with out_rdy=0 and the locked request still present, the block SHALL stay in LOCKED with lock and ptr unchanged; sel stays stable.
REQ-018 In IDLE with reqs=000, the block SHALL drive out_val=0, grants=000 and sel=0; state and ptr are unchanged.
REQ-019 Grant latency SHALL be zero cycles: a request arriving with out_rdy=1 in IDLE is granted in the same cycle.
REQ-020 At most one grants bit SHALL be set in any cycle, and grants SHALL never be set for an input whose reqs bit is 0.
REQ-021 ptr SHALL always be one-hot.
REQ-022 lock SHALL be one-hot while in LOCKED; its value in IDLE is don't-care and is not observable at any output.

Reset
REQ-023 While reset=1 at a rising edge, the block SHALL load state=IDLE, ptr=001 and lock=000, including when reset is applied mid-LOCKED.
REQ-024 During the first cycle after reset, outputs SHALL follow IDLE rules with ptr=001.
REQ-025 While reset=1, grants SHALL be forced to 000 and out_val to 0.

Verification
REQ-026 Fairness: from reset, reqs=111 and out_rdy=1 for 4 cycles -> grants sequence 001, 010, 100, 001; sel sequence 0, 1, 2, 0.
REQ-027 Lock: after reset, reqs=100 with out_rdy=0 for 2 cycles, then reqs=111 with out_rdy=0, then out_rdy=1 -> sel=2 and grants=000 throughout the stall; grants=100 in the out_rdy=1 cycle; ptr=001 afterward.
REQ-028 Withdraw: LOCKED on input 1, then reqs=000 -> out_val=0 that cycle; state IDLE next cycle; ptr unchanged.
REQ-029 Reset mid-lock: LOCKED on input 2, reset pulsed for 1 cycle, then reqs=011 with out_rdy=1 -> grants=001.
REQ-030 Idle and wrap: ptr=100, reqs=011, out_rdy=1 -> grants=001 (wrap to input 0), then ptr=010; with reqs=000 -> out_val=0 and sel=0.
REQ-031 The bench SHALL assert REQ-020 and REQ-021 on every cycle of random reqs/out_rdy stimulus (at least 10k cycles) and check no starvation: a continuously requesting input is granted within 3 transfers.
